// File: rtl/tinymips_mmio_timer.sv
// Memory-mapped prescaled 16-bit timer on the TinyMIPS RAM bus (CTRL/COUNT/COMPARE/STATUS).
// Define TIMER_AUTORELOAD_EN to implement CTRL.reload (COUNT returns to 0 on a compare match).
module tinymips_mmio_timer #(
  parameter int unsigned           SIZE     = 8,
  parameter logic [SIZE-1:0]       BASE     = 8'hF0,
  parameter int unsigned           PRESCALE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrEn,
  input  logic [SIZE-1:0] addr,
  input  logic [15:0]     data_in,
  output logic [15:0]     data_out,
  output logic            hit,
  output logic            irq
);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_COUNT   = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

`ifdef TIMER_AUTORELOAD_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [2:0]  ctrl_q,    ctrl_d;
  logic [15:0] count_q,   count_d;
  logic [15:0] compare_q, compare_d;
  logic        match_q,   match_d;
  logic [15:0] presc_q,   presc_d;
  logic [15:0] rdata_q,   rdata_d;
  logic        hit_q,     hit_d;

  logic        in_win;
  reg_sel_e    sel;
  logic        wr;
  logic        tick;
  logic        match_now;
  logic [15:0] count_inc;

  // BASE is 4-aligned, so the window is every address sharing BASE's upper bits.
  assign in_win    = (addr[SIZE-1:2] == BASE[SIZE-1:2]);
  assign sel       = reg_sel_e'(addr[1:0]);
  assign wr        = wrEn && in_win;
  assign tick      = ctrl_q[0] && (presc_q == PRESC_LAST);
  assign count_inc = count_q + 16'd1;
  assign match_now = tick && !(wr && sel == REG_COUNT) && (count_inc == compare_q);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    compare_d = compare_q;
    match_d   = match_q;
    presc_d   = 16'd0;
    rdata_d   = 16'd0;
    hit_d     = in_win;

    if (ctrl_q[0] && !tick) presc_d = presc_q + 16'd1;

    // A CPU store to COUNT overrides the tick entirely.
    if (wr && sel == REG_COUNT)   count_d = data_in;
    else if (match_now && ctrl_q[2]) count_d = 16'd0;
    else if (tick)                count_d = count_inc;

    if (match_now)                                    match_d = 1'b1;
    else if (wr && sel == REG_STATUS && data_in[0])   match_d = 1'b0;

    if (wr && sel == REG_CTRL)    ctrl_d    = data_in[2:0] & CTRL_MASK;
    if (wr && sel == REG_COMPARE) compare_d = data_in;

    if (in_win) begin
      unique case (sel)
        REG_CTRL:    rdata_d = {13'd0, ctrl_q};
        REG_COUNT:   rdata_d = count_q;
        REG_COMPARE: rdata_d = compare_q;
        REG_STATUS:  rdata_d = {15'd0, match_q};
        default:     rdata_d = 16'd0;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= 3'd0;
      count_q   <= 16'd0;
      compare_q <= 16'hFFFF;
      match_q   <= 1'b0;
      presc_q   <= 16'd0;
      rdata_q   <= 16'd0;
      hit_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      presc_q   <= presc_d;
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
    end
  end

  assign data_out = rdata_q;
  assign hit      = hit_q;
  assign irq      = match_q & ctrl_q[1];

endmodule

// File: tb/tb_tinymips_mmio_timer.sv
// Self-checking bench for tinymips_mmio_timer: directed scenarios plus randomized bus traffic
// checked against a cycle-level behavioural model of the register map.
module tb_tinymips_mmio_timer;

  localparam int          P    = 4;
  localparam logic [7:0]  BASE = 8'hF0;
`ifdef TIMER_AUTORELOAD_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wrEn = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] data_out;
  logic        hit;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  tinymips_mmio_timer #(.SIZE(8), .BASE(8'hF0), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .addr(addr),
    .data_in(data_in), .data_out(data_out), .hit(hit), .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: registers as plain values, prescaler as enabled-cycle phase modulo P.
  logic [2:0]  m_ctrl;
  logic [15:0] m_count, m_cmp, m_rd;
  logic        m_match, m_hit;
  int          m_phase;

  function automatic void model_reset();
    m_ctrl = 3'd0; m_count = 16'd0; m_cmp = 16'hFFFF; m_match = 1'b0;
    m_rd = 16'd0; m_hit = 1'b0; m_phase = 0;
  endfunction

  function automatic bit m_will_tick();
    return m_ctrl[0] && (m_phase == P - 1);
  endfunction

  function automatic bit m_will_match();
    return m_will_tick() && (16'(m_count + 16'd1) == m_cmp);
  endfunction

  function automatic void model_step(input bit we, input logic [7:0] a, input logic [15:0] d);
    int          off;
    bit          inwin, tick, fire;
    logic [15:0] nxt;
    off   = int'(a) - int'(BASE);
    inwin = (off >= 0) && (off <= 3);
    tick  = m_will_tick();
    nxt   = 16'((int'(m_count) + 1) % 65536);
    fire  = 1'b0;
    m_hit = inwin;
    if (!inwin)        m_rd = 16'd0;
    else if (off == 0) m_rd = {13'd0, m_ctrl};
    else if (off == 1) m_rd = m_count;
    else if (off == 2) m_rd = m_cmp;
    else               m_rd = {15'd0, m_match};
    m_phase = m_ctrl[0] ? (m_phase + 1) % P : 0;
    if (we && inwin && off == 1) m_count = d;
    else if (tick) begin
      fire    = (nxt == m_cmp);
      m_count = (fire && m_ctrl[2]) ? 16'd0 : nxt;
    end
    if (fire) m_match = 1'b1;
    else if (we && inwin && off == 3 && d[0]) m_match = 1'b0;
    if (we && inwin && off == 0) m_ctrl = d[2:0] & CTRL_MASK;
    if (we && inwin && off == 2) m_cmp = d;
  endfunction

  // One bus cycle: drive at the falling edge, model the rising edge, return at the next falling edge.
  task automatic bus(input bit we, input logic [7:0] a, input logic [15:0] d);
    wrEn = we; addr = a; data_in = d;
    @(posedge clk);
    model_step(we, a, d);
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_vals [4];
    exp_vals = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, BASE + 8'(i), 16'h0);
      n_checks++;
      if (data_out !== exp_vals[i] || hit !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_read off=%0d: data_out=%h hit=%b, want %h hit=1", i, data_out, hit, exp_vals[i]);
      end
    end
    bus(1'b0, 8'h10, 16'h0);
    n_checks++;
    if (data_out !== 16'h0 || hit !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outside: data_out=%h hit=%b irq=%b, want 0000 0 0", data_out, hit, irq);
    end
  endtask

  task automatic test_counting();
    int idle;
    do_reset();
    bus(1'b1, BASE, 16'h0001);
    idle = 30 + int'($urandom_range(0, 20));
    for (int i = 0; i < idle; i++) bus(1'b0, 8'h00, 16'($urandom));
    bus(1'b0, BASE + 8'd1, 16'h0);
    n_checks++;
    if (data_out !== m_rd) begin
      n_fail++;
      $display("FAIL count_after_%0d: COUNT=%h, want %h", idle, data_out, m_rd);
    end
  endtask

  task automatic test_match_irq();
    do_reset();
    bus(1'b1, BASE + 8'd2, 16'd3);
    bus(1'b1, BASE, 16'h0003);
    for (int i = 0; i < 12; i++) bus(1'b0, 8'h00, 16'h0);
    bus(1'b0, BASE + 8'd3, 16'h0);
    n_checks++;
    if (data_out !== 16'h0001 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL match_set: STATUS=%h irq=%b, want 0001 1", data_out, irq);
    end
    bus(1'b1, BASE + 8'd3, 16'h0001);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: irq=%b, want 0", irq);
    end
    for (int i = 0; i < 10; i++) begin
      bus(1'b0, BASE + 8'd1, 16'h0);
      n_checks++;
      if (data_out !== m_rd || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL count_continue[%0d]: COUNT=%h irq=%b, want %h 0", i, data_out, irq, m_rd);
      end
    end
  endtask

  task automatic test_collisions();
    int budget;
    do_reset();
    bus(1'b1, BASE, 16'h0001);
    budget = 0;
    while (!m_will_tick() && budget < 20) begin bus(1'b0, 8'h00, 16'h0); budget++; end
    bus(1'b1, BASE + 8'd1, 16'h0100);
    bus(1'b0, BASE + 8'd1, 16'h0);
    n_checks++;
    if (data_out !== 16'h0100 || budget >= 20) begin
      n_fail++;
      $display("FAIL count_write_on_tick: COUNT=%h, want 0100 (budget=%0d)", data_out, budget);
    end
    bus(1'b1, BASE + 8'd2, 16'(m_count + 16'd2));
    budget = 0;
    while (!m_will_match() && budget < 40) begin bus(1'b0, 8'h00, 16'h0); budget++; end
    bus(1'b1, BASE + 8'd3, 16'h0001);
    bus(1'b0, BASE + 8'd3, 16'h0);
    n_checks++;
    if (data_out !== 16'h0001 || budget >= 40) begin
      n_fail++;
      $display("FAIL w1c_vs_match: STATUS=%h, want 0001 (budget=%0d)", data_out, budget);
    end
  endtask

  task automatic test_wrap();
    int budget;
    do_reset();
    bus(1'b1, BASE + 8'd2, 16'd5);
    bus(1'b1, BASE, 16'h0001);
    bus(1'b1, BASE + 8'd1, 16'hFFFF);
    budget = 0;
    while (!m_will_tick() && budget < 20) begin bus(1'b0, 8'h00, 16'h0); budget++; end
    bus(1'b0, 8'h00, 16'h0);
    bus(1'b0, BASE + 8'd1, 16'h0);
    n_checks++;
    if (data_out !== 16'h0000 || budget >= 20) begin
      n_fail++;
      $display("FAIL wrap_count: COUNT=%h, want 0000", data_out);
    end
    bus(1'b0, BASE + 8'd3, 16'h0);
    n_checks++;
    if (data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_status: STATUS=%h, want 0000", data_out);
    end
  endtask

  task automatic test_reload();
    logic [15:0] seq [6];
    int budget;
    seq = '{16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0};
    do_reset();
    bus(1'b1, BASE + 8'd2, 16'd3);
    bus(1'b1, BASE, 16'h0007);
    for (int i = 0; i < 6; i++) begin
      budget = 0;
      while (!m_will_tick() && budget < 20) begin bus(1'b0, 8'h00, 16'h0); budget++; end
      bus(1'b0, 8'h00, 16'h0);
      bus(1'b0, BASE + 8'd1, 16'h0);
`ifdef TIMER_AUTORELOAD_EN
      n_checks++;
      if (data_out !== seq[i] || data_out !== m_rd) begin
        n_fail++;
        $display("FAIL reload_seq[%0d]: COUNT=%h, want %h", i, data_out, seq[i]);
      end
`else
      n_checks++;
      if (data_out !== m_rd || data_out !== 16'(i + 1)) begin
        n_fail++;
        $display("FAIL no_reload_seq[%0d]: COUNT=%h, want %h", i, data_out, m_rd);
      end
`endif
    end
    bus(1'b0, BASE, 16'h0);
    n_checks++;
    if (data_out !== {13'd0, CTRL_MASK}) begin
      n_fail++;
      $display("FAIL ctrl_readback: CTRL=%h, want %h", data_out, {13'd0, CTRL_MASK});
    end
    bus(1'b0, BASE + 8'd3, 16'h0);
    n_checks++;
    if (data_out !== {15'd0, m_match}) begin
      n_fail++;
      $display("FAIL reload_status: STATUS=%h, want %h", data_out, {15'd0, m_match});
    end
  endtask

  task automatic test_random();
    bit          we;
    logic [7:0]  a;
    logic [15:0] d;
    int          r;
    do_reset();
    bus(1'b1, BASE, 16'h0003);
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 9));
      a  = (r < 8) ? BASE + 8'(r % 4) : 8'($urandom);
      we = ($urandom_range(0, 9) < 3);
      d  = 16'($urandom);
      if (a == BASE)        d = {13'd0, 3'($urandom_range(0, 7)) | 3'b001};
      if (a == BASE + 8'd2) d = 16'(m_count + 16'($urandom_range(1, 6)));
      if (a == BASE + 8'd1 && $urandom_range(0, 3) == 0) d = 16'hFFFF;
      bus(we, a, d);
      n_checks++;
      if (data_out !== m_rd || hit !== m_hit || irq !== (m_match & m_ctrl[1])) begin
        n_fail++;
        $display("FAIL random[%0d] addr=%h we=%b: data_out=%h hit=%b irq=%b, want %h %b %b",
                 i, a, we, data_out, hit, irq, m_rd, m_hit, m_match & m_ctrl[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    int budget;
    do_reset();
    bus(1'b1, BASE + 8'd2, 16'd2);
    bus(1'b1, BASE, 16'h0003);
    budget = 0;
    while (!m_match && budget < 40) begin bus(1'b0, 8'h00, 16'h0); budget++; end
    bus(1'b0, BASE + 8'd1, 16'h0);
    n_checks++;
    if (irq !== 1'b1 || data_out !== m_count) begin
      n_fail++;
      $display("FAIL pre_reset: irq=%b COUNT=%h, want 1 %h", irq, data_out, m_count);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (irq !== 1'b0 || data_out !== 16'h0 || hit !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: irq=%b data_out=%h hit=%b, want 0 0000 0", irq, data_out, hit);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    bus(1'b0, BASE + 8'd1, 16'h0);
    n_checks++;
    if (data_out !== 16'h0) begin
      n_fail++;
      $display("FAIL post_reset_count: COUNT=%h, want 0000", data_out);
    end
    bus(1'b0, BASE + 8'd3, 16'h0);
    n_checks++;
    if (data_out !== 16'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_status: STATUS=%h irq=%b, want 0000 0", data_out, irq);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_counting();
    test_match_irq();
    test_collisions();
    test_wrap();
    test_reload();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
